// File: rtl/cache_tag_ctrl.sv
// cache_tag_ctrl: lookup/refill controller in front of a direct-mapped tag array.
// Owns the per-entry valid bits, issues line refills on a miss, and counts hits/misses.
module cache_tag_ctrl #(
  parameter int unsigned TAG_W  = 20,
  parameter int unsigned IDX_W  = 10,
  parameter int unsigned OFF_W  = 2,
  parameter int unsigned ADDR_W = TAG_W + IDX_W + OFF_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              flush,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic [IDX_W-1:0]  tag_addr,
  input  logic [TAG_W-1:0]  tag_rd,
  output logic              tag_up_en,
  output logic [IDX_W-1:0]  tag_up_addr,
  output logic [TAG_W-1:0]  tag_new_tag,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
);
  localparam int unsigned ENTRIES = 1 << IDX_W;
  localparam int unsigned CNT_W   = 32;

  typedef enum logic [1:0] {IDLE, COMPARE, MISS, FILL} state_t;

  state_t              r_state;
  logic [TAG_W-1:0]    r_tag;
  logic [IDX_W-1:0]    r_idx;
  logic [ENTRIES-1:0]  r_valid;
  logic                r_resp_valid;
  logic                r_resp_hit;
  logic                r_tag_up_en;
  logic [IDX_W-1:0]    r_tag_up_addr;
  logic [TAG_W-1:0]    r_tag_new_tag;
  logic                r_mem_req;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [CNT_W-1:0]    r_hit_cnt;
  logic [CNT_W-1:0]    r_miss_cnt;

  logic [TAG_W-1:0]    w_req_tag;
  logic [IDX_W-1:0]    w_req_idx;
  logic                w_idle;
  logic                w_hit;
  logic                w_unused_off;

  assign w_req_tag    = req_addr[ADDR_W-1 -: TAG_W];
  assign w_req_idx    = req_addr[OFF_W +: IDX_W];
  assign w_unused_off = ^req_addr[OFF_W-1:0];
  assign w_idle       = (r_state == IDLE);
  assign w_hit        = r_valid[r_idx] && (tag_rd == r_tag);

  // The array sees the live request index while idle so its read lands in COMPARE.
  assign req_ready = w_idle && !flush;
  assign tag_addr  = w_idle ? w_req_idx : r_idx;

  assign resp_valid  = r_resp_valid;
  assign resp_hit    = r_resp_hit;
  assign tag_up_en   = r_tag_up_en;
  assign tag_up_addr = r_tag_up_addr;
  assign tag_new_tag = r_tag_new_tag;
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign hit_cnt     = r_hit_cnt;
  assign miss_cnt    = r_miss_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_tag         <= '0;
      r_idx         <= '0;
      r_valid       <= '0;
      r_resp_valid  <= 1'b0;
      r_resp_hit    <= 1'b0;
      r_tag_up_en   <= 1'b0;
      r_tag_up_addr <= '0;
      r_tag_new_tag <= '0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_hit_cnt     <= '0;
      r_miss_cnt    <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_hit   <= 1'b0;
      r_tag_up_en  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (flush) begin
            r_valid <= '0;
          end else if (req_valid) begin
            r_tag   <= w_req_tag;
            r_idx   <= w_req_idx;
            r_state <= COMPARE;
          end
        end
        COMPARE: begin
          if (w_hit) begin
            r_resp_valid <= 1'b1;
            r_resp_hit   <= 1'b1;
            r_hit_cnt    <= (r_hit_cnt == '1) ? r_hit_cnt : r_hit_cnt + CNT_W'(1);
            r_state      <= IDLE;
          end else begin
            r_mem_req  <= 1'b1;
            r_mem_addr <= {r_tag, r_idx, OFF_W'(0)};
            r_state    <= MISS;
          end
        end
        MISS: begin
          if (mem_ack) begin
            r_mem_req     <= 1'b0;
            r_tag_up_en   <= 1'b1;
            r_tag_up_addr <= r_idx;
            r_tag_new_tag <= r_tag;
            r_resp_valid  <= 1'b1;
            r_miss_cnt    <= (r_miss_cnt == '1) ? r_miss_cnt : r_miss_cnt + CNT_W'(1);
            r_state       <= FILL;
          end
        end
        FILL: begin
          r_valid[r_idx] <= 1'b1;
          r_state        <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Directed bench for cache_tag_ctrl with a behavioural 1-cycle-latency tag array.
module tb_cache_tag_ctrl;
  localparam int unsigned TAG_W  = 20;
  localparam int unsigned IDX_W  = 10;
  localparam int unsigned OFF_W  = 2;
  localparam int unsigned ADDR_W = 32;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr = '0;
  logic              flush = 1'b0;
  logic              resp_valid, resp_hit;
  logic [IDX_W-1:0]  tag_addr;
  logic [TAG_W-1:0]  tag_rd = '0;
  logic              tag_up_en;
  logic [IDX_W-1:0]  tag_up_addr;
  logic [TAG_W-1:0]  tag_new_tag;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack = 1'b0;
  logic [31:0]       hit_cnt, miss_cnt;

  int n_vec = 0;
  int n_err = 0;

  logic [TAG_W-1:0] tarr [1024];
  logic [TAG_W-1:0] sweep_tag [1024];

  cache_tag_ctrl #(.TAG_W(TAG_W), .IDX_W(IDX_W), .OFF_W(OFF_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .flush(flush), .resp_valid(resp_valid), .resp_hit(resp_hit),
    .tag_addr(tag_addr), .tag_rd(tag_rd), .tag_up_en(tag_up_en),
    .tag_up_addr(tag_up_addr), .tag_new_tag(tag_new_tag), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_ack(mem_ack), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Tag array: synchronous read with one cycle of latency plus a write port.
  always @(posedge clk) begin
    if (tag_up_en) tarr[tag_up_addr] <= tag_new_tag;
    tag_rd <= tarr[tag_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // One request; acks a refill after ack_dly cycles and reports what was seen.
  task automatic lookup(input logic [ADDR_W-1:0] addr, input int ack_dly,
                        output logic hit, output logic mreq, output logic mheld,
                        output logic [ADDR_W-1:0] maddr, output logic miss_resp,
                        output logic upen, output logic [IDX_W-1:0] upaddr,
                        output logic [TAG_W-1:0] uptag);
    hit = 1'b0; mreq = 1'b0; mheld = 1'b1; maddr = '0; miss_resp = 1'b0;
    upen = 1'b0; upaddr = '0; uptag = '0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    if (resp_valid && resp_hit) begin
      hit = 1'b1;
      mreq = mem_req;
    end else if (mem_req) begin
      mreq = 1'b1;
      maddr = mem_addr;
      repeat (ack_dly) begin
        @(negedge clk);
        if (!mem_req || mem_addr !== maddr) mheld = 1'b0;
      end
      mem_ack = 1'b1;
      @(negedge clk);
      mem_ack = 1'b0;
      miss_resp = resp_valid && !resp_hit && !mem_req;
      upen = tag_up_en; upaddr = tag_up_addr; uptag = tag_new_tag;
      @(posedge clk);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++; if (resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid got %b want 0", resp_valid); end
    n_vec++; if (resp_hit !== 1'b0) begin n_err++; $display("FAIL reset_resp_hit got %b want 0", resp_hit); end
    n_vec++; if (tag_up_en !== 1'b0) begin n_err++; $display("FAIL reset_tag_up_en got %b want 0", tag_up_en); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    n_vec++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr got %h want 0", mem_addr); end
    n_vec++; if (tag_up_addr !== 10'h0 || tag_new_tag !== 20'h0) begin n_err++; $display("FAIL reset_tag_up got %h/%h want 0/0", tag_up_addr, tag_new_tag); end
    n_vec++; if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin n_err++; $display("FAIL reset_counters got %0d/%0d want 0/0", hit_cnt, miss_cnt); end
    n_vec++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
  endtask

  task automatic test_first_miss();
    logic h, mr, mh, mresp, ue; logic [ADDR_W-1:0] ma; logic [IDX_W-1:0] ua; logic [TAG_W-1:0] ut;
    lookup(32'h0000_1234, 5, h, mr, mh, ma, mresp, ue, ua, ut);
    n_vec++; if (h !== 1'b0 || mr !== 1'b1) begin n_err++; $display("FAIL miss1_kind got hit=%b mem_req=%b want 0/1", h, mr); end
    n_vec++; if (ma !== 32'h0000_1234) begin n_err++; $display("FAIL miss1_mem_addr got %h want 00001234", ma); end
    n_vec++; if (mh !== 1'b1) begin n_err++; $display("FAIL miss1_mem_hold got %b want 1", mh); end
    n_vec++; if (ue !== 1'b1 || ua !== 10'h08D || ut !== 20'h00001) begin n_err++; $display("FAIL miss1_update got en=%b addr=%h tag=%h want 1/08d/00001", ue, ua, ut); end
    n_vec++; if (mresp !== 1'b1) begin n_err++; $display("FAIL miss1_resp got %b want 1", mresp); end
    n_vec++; if (miss_cnt !== 32'd1 || hit_cnt !== 32'd0) begin n_err++; $display("FAIL miss1_counts got %0d/%0d want 0/1", hit_cnt, miss_cnt); end
  endtask

  task automatic test_hit_after_fill();
    logic h, mr, mh, mresp, ue; logic [ADDR_W-1:0] ma; logic [IDX_W-1:0] ua; logic [TAG_W-1:0] ut;
    lookup(32'h0000_1237, 5, h, mr, mh, ma, mresp, ue, ua, ut);
    n_vec++; if (h !== 1'b1) begin n_err++; $display("FAIL hit1_latency got hit=%b want 1 one cycle after accept", h); end
    n_vec++; if (mr !== 1'b0) begin n_err++; $display("FAIL hit1_no_mem_req got %b want 0", mr); end
    n_vec++; if (hit_cnt !== 32'd1) begin n_err++; $display("FAIL hit1_count got %0d want 1", hit_cnt); end
  endtask

  task automatic test_replace();
    logic h, mr, mh, mresp, ue; logic [ADDR_W-1:0] ma; logic [IDX_W-1:0] ua; logic [TAG_W-1:0] ut;
    lookup(32'h0000_2234, 2, h, mr, mh, ma, mresp, ue, ua, ut);
    n_vec++; if (h !== 1'b0 || ma !== 32'h0000_2234 || ut !== 20'h00002 || ua !== 10'h08D) begin n_err++; $display("FAIL replace_miss got hit=%b addr=%h tag=%h idx=%h want 0/00002234/00002/08d", h, ma, ut, ua); end
    lookup(32'h0000_1234, 1, h, mr, mh, ma, mresp, ue, ua, ut);
    n_vec++; if (h !== 1'b0 || mr !== 1'b1) begin n_err++; $display("FAIL replaced_tag got hit=%b mem_req=%b want 0/1", h, mr); end
    n_vec++; if (miss_cnt !== 32'd3 || hit_cnt !== 32'd1) begin n_err++; $display("FAIL replace_counts got %0d/%0d want 1/3", hit_cnt, miss_cnt); end
  endtask

  task automatic test_sweep();
    logic h, mr, mh, mresp, ue; logic [ADDR_W-1:0] ma; logic [IDX_W-1:0] ua; logic [TAG_W-1:0] ut;
    int bad;
    apply_reset();
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      sweep_tag[i] = TAG_W'($urandom);
      lookup({sweep_tag[i], IDX_W'(i), 2'b00}, 1 + (i % 3), h, mr, mh, ma, mresp, ue, ua, ut);
      if (h || !mr || !mresp || !ue || ua !== IDX_W'(i) || ut !== sweep_tag[i]) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL sweep_fill got %0d bad refills want 0", bad); end
    n_vec++; if (miss_cnt !== 32'd1024) begin n_err++; $display("FAIL sweep_miss_cnt got %0d want 1024", miss_cnt); end
    bad = 0;
    for (int i = 0; i < 1024; i++) begin
      lookup({sweep_tag[i], IDX_W'(i), 2'($urandom)}, 1, h, mr, mh, ma, mresp, ue, ua, ut);
      if (!h || mr) bad++;
    end
    n_vec++; if (bad != 0) begin n_err++; $display("FAIL sweep_reread got %0d non-hits want 0", bad); end
    n_vec++; if (hit_cnt !== 32'd1024) begin n_err++; $display("FAIL sweep_hit_cnt got %0d want 1024", hit_cnt); end
  endtask

  task automatic test_flush();
    logic h, mr, mh, mresp, ue; logic [ADDR_W-1:0] ma; logic [IDX_W-1:0] ua; logic [TAG_W-1:0] ut;
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; req_addr = {sweep_tag[5], 10'd5, 2'b00};
    #1;
    n_vec++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL flush_req_ready got %b want 0", req_ready); end
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (resp_valid !== 1'b0 || mem_req !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL flush_no_accept got resp=%b mem_req=%b ready=%b want 0/0/1", resp_valid, mem_req, req_ready); end
    lookup({sweep_tag[5], 10'd5, 2'b00}, 1, h, mr, mh, ma, mresp, ue, ua, ut);
    n_vec++; if (h !== 1'b0 || mr !== 1'b1) begin n_err++; $display("FAIL flush_then_miss got hit=%b mem_req=%b want 0/1", h, mr); end
    n_vec++; if (hit_cnt !== 32'd1024 || miss_cnt !== 32'd1025) begin n_err++; $display("FAIL flush_keeps_counts got %0d/%0d want 1024/1025", hit_cnt, miss_cnt); end
  endtask

  task automatic test_reset_mid_refill();
    logic seen;
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h0005_5550;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL midreset_in_miss got mem_req=%b want 1", mem_req); end
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    n_vec++; if (mem_req !== 1'b0 || req_ready !== 1'b1) begin n_err++; $display("FAIL midreset_abort got mem_req=%b ready=%b want 0/1", mem_req, req_ready); end
    @(negedge clk);
    @(negedge clk);
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    seen = tag_up_en | resp_valid | mem_req;
    @(negedge clk);
    seen = seen | tag_up_en | resp_valid | mem_req;
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL midreset_stray_ack got activity=%b want 0", seen); end
    n_vec++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0 || req_ready !== 1'b1) begin n_err++; $display("FAIL midreset_state got %0d/%0d ready=%b want 0/0/1", hit_cnt, miss_cnt, req_ready); end
  endtask

  task automatic test_saturation();
    logic h, mr, mh, mresp, ue; logic [ADDR_W-1:0] ma; logic [IDX_W-1:0] ua; logic [TAG_W-1:0] ut;
    lookup(32'h0ABC_D120, 1, h, mr, mh, ma, mresp, ue, ua, ut);
    @(negedge clk);
    force dut.r_hit_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_hit_cnt;
    lookup(32'h0ABC_D121, 1, h, mr, mh, ma, mresp, ue, ua, ut);
    n_vec++; if (h !== 1'b1 || hit_cnt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_first got hit=%b cnt=%h want 1/ffffffff", h, hit_cnt); end
    lookup(32'h0ABC_D122, 1, h, mr, mh, ma, mresp, ue, ua, ut);
    lookup(32'h0ABC_D123, 1, h, mr, mh, ma, mresp, ue, ua, ut);
    n_vec++; if (h !== 1'b1 || hit_cnt !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sat_hold got hit=%b cnt=%h want 1/ffffffff", h, hit_cnt); end
    n_vec++; if (miss_cnt !== 32'd1) begin n_err++; $display("FAIL sat_miss_cnt got %0d want 1", miss_cnt); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) tarr[i] = '0;
    test_reset();
    test_first_miss();
    test_hit_after_fill();
    test_replace();
    test_sweep();
    test_flush();
    test_reset_mid_refill();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cache_tag_ctrl.md
Name: cache_tag_ctrl

Overview:
- Lookup/refill controller that sits directly in front of the direct-mapped tag array in the branch-predictor cache path.
- Accepts address lookup requests and drives the tag array read index.
- Compares the returned tag against the request and keeps the per-entry valid bits.
- On a miss, issues a refill request to memory and then writes the new tag into the array through its update port. It also keeps hit and miss statistics.

Parameters:
TAG_W, 20, tag width; equals the tag array entry width
IDX_W, 10, index width; the array holds 2^IDX_W entries
OFF_W, 2, byte-offset width; ignored for lookup
ADDR_W, TAG_W+IDX_W+OFF_W (32), request/memory address width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-low reset
req_valid  in  1  lookup request present
req_ready  out  1  controller can accept a request
req_addr  in  ADDR_W  lookup address {tag, index, offset}
flush  in  1  invalidate all entries
resp_valid  out  1  one-cycle lookup result strobe
resp_hit  out  1  1=hit, 0=miss (refilled); valid only with resp_valid
tag_addr  out  IDX_W  tag array read index
tag_rd  in  TAG_W  tag array read data; 1-cycle synchronous read latency
tag_up_en  out  1  tag array write enable
tag_up_addr  out  IDX_W  tag array write index
tag_new_tag  out  TAG_W  tag array write data
mem_req  out  1  refill request
mem_addr  out  ADDR_W  refill line address {tag, index, OFF_W'b0}
mem_ack  in  1  refill complete, single-cycle pulse
hit_cnt  out  32  saturating hit counter
miss_cnt  out  32  saturating miss counter

Behaviour:
- Reset is sampled on the clk rising edge with reset==0. It forces:
  - state IDLE;
  - all valid bits cleared;
  - hit_cnt and miss_cnt = 0;
  - resp_valid, resp_hit, tag_up_en, mem_req = 0;
  - mem_addr, tag_up_addr, tag_new_tag, latched address = 0.
- Reset mid-refill aborts the refill: mem_req drops and no tag write occurs.
- FSM states: IDLE, COMPARE, MISS, FILL. All outputs are registered except req_ready and tag_addr.
- IDLE:
  - req_ready = !flush. tag_addr = req_addr index (combinational).
  - flush==1 clears all valid bits at the edge and no request is accepted. Flush is ignored outside IDLE.
  - req_valid && req_ready at edge E0 latches req_addr and moves to COMPARE. The tag array captures the index at E0.
- COMPARE (one cycle):
  - tag_addr holds the latched index. tag_rd is valid.
  - Hit = valid[idx] && (tag_rd == latched tag).
  - Hit: at E1 go to IDLE; resp_valid=1, resp_hit=1 for one cycle; hit_cnt += 1.
  - Miss: at E1 go to MISS; mem_req=1, mem_addr = {tag, idx, 0}.
- MISS:
  - mem_req and mem_addr are held stable until mem_ack==1 is sampled.
  - Then go to FILL, with mem_req=0, tag_up_en=1, tag_up_addr=idx, tag_new_tag=tag, resp_valid=1, resp_hit=0, miss_cnt += 1.
- FILL (one cycle): at the next edge the tag array writes and valid[idx] is set. Then go to IDLE; tag_up_en and resp_valid return to 0.
- Hit latency is 1 cycle after accept. Miss latency is 2 cycles after the mem_ack edge relative to the request.
- req_ready = 0 in COMPARE, MISS and FILL. Back-to-back hits therefore sustain one request every 2 cycles.
- A request to the just-filled index, accepted in the cycle after FILL, must hit: the write and the valid bit are both committed before the read.
- mem_ack outside MISS is ignored.
- Counters saturate at 32'hFFFF_FFFF and do not wrap. Flush does not clear the counters.
- Tag compare is a full TAG_W-bit equality check. Offset bits never affect hit/miss.

Test Plan:
- Reset release, then req_addr=32'h0000_1234 -> miss: mem_req=1 with mem_addr=32'h0000_1234 & ~3. With mem_ack after 5 cycles, expect tag_up_en=1 at tag_up_addr=10'h08D with tag_new_tag=20'h00001, plus resp_valid=1/resp_hit=0; miss_cnt=1.
- Repeat 32'h0000_1237 immediately after FILL -> hit 1 cycle after accept; hit_cnt=1, no mem_req.
- Same index, different tag (32'h0000_2234) -> miss and refill. A subsequent 32'h0000_1234 -> miss (tag was replaced).
- Fill indices 0..1023 with random tags (matching the tag array's 1024-entry sweep), then re-read all of them -> 1024 hits, hit_cnt=1024.
- flush in IDLE with req_valid high -> req_ready=0 that cycle. The next lookup to a previously filled address misses.
- Assert reset during MISS, and pulse mem_ack 2 cycles after reset -> no tag_up_en, no resp_valid, state IDLE, counters 0. Force hit_cnt to 32'hFFFF_FFFE and issue 3 hits -> count holds at 32'hFFFF_FFFF.
